sm4_mask_rng_sched: RTL
=======================

Name: sm4_mask_rng_sched

Overview:
- Schedules and shares the 128-bit mask random word from the NLFSR mask generator among NREQ masked SM4 datapath units.
- Drives the generator's advance enable. Runs a warm-up after reset.
- Splits each captured 128-bit word into four 32-bit mask slices. Grants each slice exactly once, round-robin, then refills.
- Sits between the mask generator and the masked round/key-expansion units.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WARMUP, 16, generator steps issued after reset before the first capture (1..255).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rand_in  in  128  current generator output word.
- rng_step  out  1  generator advance enable; generator updates on the edge where this is 1.
- req  in  NREQ  per-requester mask request, level; held until granted.
- gnt  out  NREQ  one-hot grant pulse, 1 cycle.
- mask_out  out  32  granted mask slice; valid only when mask_valid=1.
- mask_valid  out  1  equals |gnt.
- ready  out  1  1 in SERVE state.
- stuck_err  out  1  sticky error flag; see Optional Feature.

Behaviour:
- Reset (async, rst=1): state=WARMUP, warm counter=0, slice_ptr=0, rr_last=NREQ-1.
- Reset values of outputs: gnt=0, mask_out=0, mask_valid=0, rng_step=0, ready=0, stuck_err=0.
- Reset mid-operation aborts everything. Any grant in flight is dropped, the buffer is discarded, and the block restarts the warm-up.
- States:
  - WARMUP: rng_step=1 every cycle. Counter increments. After WARMUP steps, go to REFILL with rng_step=0.
  - REFILL: one cycle. buf <= rand_in. slice_ptr <= 0. Next state is SERVE.
  - SERVE: ready=1. If req != 0:
    - Select winner i = first set bit searching upward from rr_last+1, modulo NREQ.
    - Next cycle: gnt[i]=1, mask_out=buf slice selected by slice_ptr, mask_valid=1.
    - rr_last <= i. slice_ptr <= slice_ptr+1.
    - Slice order: ptr0=[127:96], ptr1=[95:64], ptr2=[63:32], ptr3=[31:0].
- Slice exhaustion:
  - When the slice at ptr3 is granted, rng_step=1 in the same cycle as that gnt.
  - State then goes to REFILL, and REFILL samples the advanced word.
  - No grants are issued in REFILL or WARMUP; requests simply wait.
- Latency:
  - Request seen in SERVE -> gnt on the next cycle.
  - Exhaustion -> next grant possible no sooner than 3 cycles after the ptr3 grant.
- A requester that keeps req high after its gnt is treated as a new request. It is eligible again, at lowest priority.
- At most one grant per cycle. Back-to-back grants on consecutive cycles are allowed (throughput 1 slice/cycle in SERVE).
- A slice is never granted twice. After a refill, buf is never reused.
- Bits of req that change while not granted have no effect beyond the arbitration in that cycle.
- mask_out holds its last value when mask_valid=0.

Optional Feature:
- Macro: SM4_RNG_STUCK_CHECK_EN.
- When defined:
  - REFILL compares rand_in against the previously captured buf, excluding the first capture after reset.
  - On equality: set stuck_err=1 (sticky until rst), pulse rng_step=1, and remain in REFILL to retry.
  - SERVE is entered only with a word differing from the last one.
- When undefined: no comparison logic is built; stuck_err is tied to 0.

Test Plan:
- WARMUP=16, hold req=0 after reset release -> rng_step=1 for exactly 16 cycles, then 0; ready=1 from cycle 18.
- rand_in=0x00112233_44556677_8899AABB_CCDDEEFF captured; req=4'b0001 held -> gnt=0001 for four grants, mask_out=0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF. rng_step=1 with the fourth gnt; ready drops for REFILL.
- req=4'b1111 held in SERVE after reset -> grant order 0,1,2,3,0,1,...; one gnt per cycle; each mask_out distinct slice in ptr order.
- req=4'b1010 with rr_last=1 -> gnt=1000 first, then 0010.
- rst asserted mid-SERVE after 2 grants -> all outputs 0 asynchronously. After release: full 16-step warm-up, then ptr restarts at slice [127:96].
- With SM4_RNG_STUCK_CHECK_EN, rand_in held constant across a refill -> stuck_err=1, rng_step pulses in REFILL, ready stays 0 until rand_in changes.

Source files
------------

// File: rtl/sm4_mask_rng_sched.sv
// sm4_mask_rng_sched
// Shares the 128-bit mask word from the NLFSR mask generator among NREQ
// masked SM4 datapath units. After reset the generator is stepped WARMUP
// times. Each captured word is then handed out as four 32-bit slices, one
// grant per cycle, round-robin. When the last slice is granted the generator
// is stepped once and the advanced word is captured.
//
// Optional build macro SM4_RNG_STUCK_CHECK_EN: the refill compares the new
// word against the previous one and retries (with a sticky stuck_err) while
// they are equal. Without it no comparator is built and stuck_err is 0.
module sm4_mask_rng_sched #(
  parameter int NREQ   = 4,
  parameter int WARMUP = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [127:0]    rand_in,
  output logic            rng_step,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [31:0]     mask_out,
  output logic            mask_valid,
  output logic            ready,
  output logic            stuck_err
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_WARMUP = 2'd0,
    S_REFILL = 2'd1,
    S_SERVE  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      warm_cnt, warm_cnt_nxt;
  logic [1:0]      slice_ptr, slice_ptr_nxt;
  logic [IW-1:0]   rr_last, rr_last_nxt;
  logic            rng_step_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic            mask_valid_nxt;
  logic [31:0]     mask_nxt;
  logic            capture_p0;
  logic [127:0]    mask_buf_p0;
  logic [IW:0]     win;
  logic            win_found;
  logic [IW-1:0]   win_idx;

`ifdef SM4_RNG_STUCK_CHECK_EN
  logic            have_buf;
  logic            word_repeat;
  logic            stuck_nxt;
`endif

  // Round-robin pick: first set bit searching upward from last+1, wrapping
  // at NREQ. Returns {found, index}.
  function automatic logic [IW:0] pick_winner(input logic [NREQ-1:0] r,
                                               input logic [IW-1:0]   last);
    logic          found;
    logic [IW-1:0] idx;
    logic [IW-1:0] kk;
    int            k;
    found = 1'b0;
    idx   = '0;
    for (int s = 1; s <= NREQ; s++) begin
      k  = (int'(last) + s) % NREQ;
      kk = IW'(k);
      if (!found && r[kk]) begin
        found = 1'b1;
        idx   = kk;
      end
    end
    return {found, idx};
  endfunction

  // Slice 0 is the most significant 32 bits of the captured word.
  function automatic logic [31:0] slice_of(input logic [127:0] w,
                                           input logic [1:0]   p);
    logic [31:0] s;
    case (p)
      2'd0:    s = w[127:96];
      2'd1:    s = w[95:64];
      2'd2:    s = w[63:32];
      default: s = w[31:0];
    endcase
    return s;
  endfunction

  assign win       = pick_winner(req, rr_last);
  assign win_found = win[IW];
  assign win_idx   = win[IW-1:0];
  assign ready     = (state == S_SERVE);

`ifdef SM4_RNG_STUCK_CHECK_EN
  assign word_repeat = have_buf && (rand_in == mask_buf_p0);
`endif

  // Next-state and next-output logic. REFILL never samples on an edge where
  // the generator is being stepped, so it always captures the advanced word.
  always_comb begin
    state_nxt      = state;
    warm_cnt_nxt   = warm_cnt;
    slice_ptr_nxt  = slice_ptr;
    rr_last_nxt    = rr_last;
    rng_step_nxt   = 1'b0;
    gnt_nxt        = '0;
    mask_valid_nxt = 1'b0;
    mask_nxt       = mask_out;
    capture_p0     = 1'b0;
`ifdef SM4_RNG_STUCK_CHECK_EN
    stuck_nxt      = stuck_err;
`endif
    case (state)
      S_WARMUP: begin
        if (warm_cnt == 8'(WARMUP)) begin
          state_nxt = S_REFILL;
        end else begin
          rng_step_nxt = 1'b1;
          warm_cnt_nxt = warm_cnt + 8'd1;
        end
      end
      S_REFILL: begin
        if (!rng_step) begin
`ifdef SM4_RNG_STUCK_CHECK_EN
          if (word_repeat) begin
            stuck_nxt    = 1'b1;
            rng_step_nxt = 1'b1;
          end else begin
            capture_p0    = 1'b1;
            slice_ptr_nxt = 2'd0;
            state_nxt     = S_SERVE;
          end
`else
          capture_p0    = 1'b1;
          slice_ptr_nxt = 2'd0;
          state_nxt     = S_SERVE;
`endif
        end
      end
      S_SERVE: begin
        if (win_found) begin
          gnt_nxt        = NREQ'(1) << win_idx;
          mask_valid_nxt = 1'b1;
          mask_nxt       = slice_of(mask_buf_p0, slice_ptr);
          rr_last_nxt    = win_idx;
          slice_ptr_nxt  = slice_ptr + 2'd1;
          if (slice_ptr == 2'd3) begin
            rng_step_nxt = 1'b1;
            state_nxt    = S_REFILL;
          end
        end
      end
      default: state_nxt = S_WARMUP;
    endcase
  end

  // Control state and registered outputs; reset drops any grant in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_WARMUP;
      warm_cnt   <= '0;
      slice_ptr  <= '0;
      rr_last    <= IW'(NREQ - 1);
      rng_step   <= 1'b0;
      gnt        <= '0;
      mask_valid <= 1'b0;
      mask_out   <= '0;
    end else begin
      state      <= state_nxt;
      warm_cnt   <= warm_cnt_nxt;
      slice_ptr  <= slice_ptr_nxt;
      rr_last    <= rr_last_nxt;
      rng_step   <= rng_step_nxt;
      gnt        <= gnt_nxt;
      mask_valid <= mask_valid_nxt;
      mask_out   <= mask_nxt;
    end
  end

  // ---- stage p0: captured mask word (data only, no reset) ----
  // Mask word buffer, loaded once per refill.
  always_ff @(posedge clk) begin
    if (capture_p0) mask_buf_p0 <= rand_in;
  end

`ifdef SM4_RNG_STUCK_CHECK_EN
  // Sticky stuck flag and first-capture tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_buf  <= 1'b0;
      stuck_err <= 1'b0;
    end else begin
      stuck_err <= stuck_nxt;
      if (capture_p0) have_buf <= 1'b1;
    end
  end
`else
  assign stuck_err = 1'b0;
`endif

endmodule
